// File: rtl/shim_cfg_pkg.sv
// shim_cfg_pkg
//   Shared definitions for the SPI-domain configuration commit shim:
//   counter width, FSM state encodings and the channel index map used by
//   the configuration wrapper when packing fields into cfg_in.
package shim_cfg_pkg;

  // Width of each per-channel stability counter (STABLE_CYCLES <= 255).
  localparam int CFG_CNT_W = 8;

  // Gated-commit FSM state encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Channel slot assignments shared with the config wrapper.
  localparam int SPI_EN       = 0;
  localparam int BLOCK_BUFS   = 1;
  localparam int INTEG_THRESH = 2;
  localparam int INTEG_WINDOW = 3;
  localparam int DAC_CS_HIGH  = 4;
  localparam int ADC_CS_HIGH  = 5;
  localparam int DAC_CAL_INIT = 6;
  localparam int DEBUG        = 7;

endpackage

// File: rtl/shim_cfg_stable_filter.sv
// shim_cfg_stable_filter
//   One channel of the stability filter: samples the synchronized value
//   every cycle and counts consecutive cycles without a change. The channel
//   is stable once the counter saturates at STABLE_CYCLES.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   default_i  value loaded into the sample register during reset
//   data_i     synchronized config value
//   sample_o   last sampled value
//   stable_o   high while sample_o has been unchanged for STABLE_CYCLES
module shim_cfg_stable_filter
  import shim_cfg_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] default_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              stable_o
);

  localparam logic [CFG_CNT_W-1:0] CNT_MAX = CFG_CNT_W'(STABLE_CYCLES);

  logic [DATA_W-1:0]    sample_q;
  logic [CFG_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d; a missing
    // branch would otherwise infer a latch.
    cnt_d = cnt_q;
    if (data_i != sample_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CFG_CNT_W'(1);
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sample_q <= default_i;
      cnt_q    <= '0;
    end else begin
      sample_q <= data_i;
      cnt_q    <= cnt_d;
    end
  end

  assign sample_o = sample_q;
  assign stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/shim_spi_cfg_commit.sv
// shim_spi_cfg_commit
//   SPI-domain configuration staging. Each channel is qualified by a
//   stability filter. Live channels commit as soon as they are stable;
//   gated channels commit together, only while the SPI core reports an
//   inter-frame idle window, so sequencers never see torn updates.
// Optional feature: define SHIM_CFG_COMMIT_TIMEOUT_EN to add a sticky
//   commit_timeout flag raised after TIMEOUT_CYCLES cycles in ARMED.
// Ports:
//   spi_clk, spi_resetn  clock, synchronous active-low reset
//   cfg_in               synchronized config, channel i at [i*DATA_W +: DATA_W]
//   cfg_default          reset values, sampled while spi_resetn=0
//   live_mask            1 = channel commits without frame gating (static)
//   idle_window          high while the SPI core is between frames
//   cfg_out              committed configuration
//   cfg_changed          per-channel pulse the cycle after cfg_out changes
//   commit_pending       high while a gated commit is armed
//   commit_done          one-cycle pulse after a gated commit
//   commit_timeout       sticky timeout flag (0 when feature disabled)
module shim_spi_cfg_commit
  import shim_cfg_pkg::*;
#(
  parameter int N_CH           = 8,
  parameter int DATA_W         = 32,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   spi_clk,
  input  logic                   spi_resetn,
  input  logic [N_CH*DATA_W-1:0] cfg_in,
  input  logic [N_CH*DATA_W-1:0] cfg_default,
  input  logic [N_CH-1:0]        live_mask,
  input  logic                   idle_window,
  output logic [N_CH*DATA_W-1:0] cfg_out,
  output logic [N_CH-1:0]        cfg_changed,
  output logic                   commit_pending,
  output logic                   commit_done,
  output logic                   commit_timeout
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("shim_spi_cfg_commit: parameter out of range");
  end

  logic [N_CH*DATA_W-1:0] sample;
  logic [N_CH-1:0]        stable;
  logic [N_CH-1:0]        pend;
  logic [N_CH-1:0]        load;
  logic                   anyp;
  logic                   commit;

  logic [1:0]             state_q, state_d;
  logic [N_CH*DATA_W-1:0] cfg_out_q, cfg_out_d;
  logic [N_CH-1:0]        load_q;
  logic [N_CH-1:0]        changed_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    shim_cfg_stable_filter #(
      .DATA_W        (DATA_W),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
      .clk_i     (spi_clk),
      .rst_ni    (spi_resetn),
      .default_i (cfg_default[gi*DATA_W +: DATA_W]),
      .data_i    (cfg_in[gi*DATA_W +: DATA_W]),
      .sample_o  (sample[gi*DATA_W +: DATA_W]),
      .stable_o  (stable[gi])
    );

    // A stable value that equals the committed one is not pending, so an
    // input that reverts before settling never triggers a commit.
    assign pend[gi] = stable[gi] &&
                      (sample[gi*DATA_W +: DATA_W] != cfg_out_q[gi*DATA_W +: DATA_W]);
  end

  // Only gated channels drive the FSM.
  assign anyp = |(pend & ~live_mask);

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE:  if (anyp) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!anyp) begin
          state_d = ST_IDLE;
        end else if (idle_window) begin
          commit  = 1'b1;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Live channels load whenever pending; gated ones only on the commit edge.
  assign load = pend & (live_mask | {N_CH{commit}});

  always_comb begin
    cfg_out_d = cfg_out_q;
    for (int i = 0; i < N_CH; i++) begin
      if (load[i]) cfg_out_d[i*DATA_W +: DATA_W] = sample[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge spi_clk) begin
    if (!spi_resetn) begin
      state_q   <= ST_IDLE;
      cfg_out_q <= cfg_default;
      load_q    <= '0;
      changed_q <= '0;
    end else begin
      state_q   <= state_d;
      cfg_out_q <= cfg_out_d;
      load_q    <= load;
      changed_q <= load_q;
    end
  end

`ifdef SHIM_CFG_COMMIT_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_flag_q;

  always_ff @(posedge spi_clk) begin
    if (!spi_resetn) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_ARMED) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_ARMED && tmo_cnt_q != '1) begin
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end
      // The count after this edge reaches TIMEOUT_CYCLES.
      if (state_q == ST_ARMED && tmo_cnt_q >= 32'(TIMEOUT_CYCLES) - 32'd1) begin
        tmo_flag_q <= 1'b1;
      end
    end
  end

  assign commit_timeout = tmo_flag_q;
`else
  assign commit_timeout = 1'b0;
`endif

  assign cfg_out        = cfg_out_q;
  assign cfg_changed    = changed_q;
  assign commit_pending = (state_q == ST_ARMED);
  assign commit_done    = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_shim_spi_cfg_commit.sv
// tb_shim_spi_cfg_commit
//   Directed bench: N_CH=4, DATA_W=16, STABLE_CYCLES=4, ch0 live, ch1-3
//   gated. Edge numbers count rising edges after reset release; outputs are
//   sampled 1 time unit after each edge.
module tb_shim_spi_cfg_commit;

  localparam int N_CH   = 4;
  localparam int DATA_W = 16;
  localparam logic [63:0] DEF = {16'h00FF, 16'h001F, 16'h1000, 16'h0000};

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [N_CH*DATA_W-1:0] cfg_in;
  logic [N_CH*DATA_W-1:0] cfg_default;
  logic [N_CH-1:0]        live_mask;
  logic                   idle_window;
  logic [N_CH*DATA_W-1:0] cfg_out;
  logic [N_CH-1:0]        cfg_changed;
  logic                   commit_pending;
  logic                   commit_done;
  logic                   commit_timeout;

  int          errors = 0;
  int          checks = 0;
  int          edge_n = 0;
  logic [63:0] exp_out;

  shim_spi_cfg_commit #(
    .N_CH           (N_CH),
    .DATA_W         (DATA_W),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .spi_clk        (clk),
    .spi_resetn     (resetn),
    .cfg_in         (cfg_in),
    .cfg_default    (cfg_default),
    .live_mask      (live_mask),
    .idle_window    (idle_window),
    .cfg_out        (cfg_out),
    .cfg_changed    (cfg_changed),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .commit_timeout (commit_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got=%h exp=%h", tag, edge_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic goto_edge(input int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cfg_in = DEF;
    step();
    step();
    check("rst_cfg_out", cfg_out, DEF);
    check("rst_pending", commit_pending, 0);
    check("rst_done", commit_done, 0);
    check("rst_changed", cfg_changed, 0);
    check("rst_timeout", commit_timeout, 0);
    resetn = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    cfg_default = DEF;
    live_mask   = 4'b0001;
    idle_window = 1'b0;
    exp_out     = DEF;
    do_reset();

    // Live channel 0: change before edge 10, visible after edge 15.
    goto_edge(9);
    cfg_in[15:0] = 16'h0005;
    goto_edge(14);
    check("live_hold", cfg_out, exp_out);
    check("live_no_pend14", commit_pending, 0);
    goto_edge(15);
    exp_out[15:0] = 16'h0005;
    check("live_update", cfg_out, exp_out);
    check("live_chg_early", cfg_changed, 0);
    goto_edge(16);
    check("live_chg_pulse", cfg_changed, 4'b0001);
    check("live_no_pend16", commit_pending, 0);
    goto_edge(17);
    check("live_chg_end", cfg_changed, 0);

    // Gated ch1+ch2 together: armed after edge 35, commit at edge 40.
    goto_edge(29);
    cfg_in[31:16] = 16'h2000;
    cfg_in[47:32] = 16'h0010;
    goto_edge(34);
    check("gate_no_pend34", commit_pending, 0);
    goto_edge(35);
    check("gate_pend35", commit_pending, 1);
    check("gate_hold35", cfg_out, exp_out);
    goto_edge(39);
    check("gate_pend39", commit_pending, 1);
    check("gate_hold39", cfg_out, exp_out);
    idle_window = 1'b1;
    goto_edge(40);
    exp_out[31:16] = 16'h2000;
    exp_out[47:32] = 16'h0010;
    check("gate_commit", cfg_out, exp_out);
    check("gate_done", commit_done, 1);
    check("gate_pend_clr", commit_pending, 0);
    idle_window = 1'b0;
    goto_edge(41);
    check("gate_done_end", commit_done, 0);
    check("gate_chg_pulse", cfg_changed, 4'b0110);
    goto_edge(42);
    check("gate_chg_end", cfg_changed, 0);

    // ch3 glitches and reverts before stabilising: no activity.
    goto_edge(49);
    cfg_in[63:48] = 16'h0080;
    for (int e = 50; e <= 60; e++) begin
      goto_edge(e);
      check("glitch_pend", commit_pending, 0);
      check("glitch_chg", cfg_changed, 0);
      if (e == 51) cfg_in[63:48] = 16'h00FF;
    end
    check("glitch_out", cfg_out, exp_out);

    // ch1 moves again while armed: disarm, re-arm, commit final value only.
    goto_edge(69);
    cfg_in[31:16] = 16'h3000;
    goto_edge(75);
    check("rearm_pend75", commit_pending, 1);
    goto_edge(76);
    cfg_in[31:16] = 16'h4000;
    goto_edge(77);
    check("rearm_pend77", commit_pending, 1);
    check("rearm_hold77", cfg_out, exp_out);
    goto_edge(78);
    check("rearm_idle78", commit_pending, 0);
    goto_edge(81);
    check("rearm_idle81", commit_pending, 0);
    goto_edge(82);
    check("rearm_pend82", commit_pending, 1);
    idle_window = 1'b1;
    goto_edge(83);
    exp_out[31:16] = 16'h4000;
    check("rearm_commit", cfg_out, exp_out);
    check("rearm_done", commit_done, 1);
    idle_window = 1'b0;
    goto_edge(84);
    check("rearm_chg", cfg_changed, 4'b0010);

    // Reset while armed discards the pending commit.
    goto_edge(89);
    cfg_in[47:32] = 16'h0020;
    goto_edge(95);
    check("mid_arm_pend", commit_pending, 1);
    do_reset();
    exp_out = DEF;

`ifdef SHIM_CFG_COMMIT_TIMEOUT_EN
    // Armed after edge 6; timeout flag after edge 106; sticky past commit.
    cfg_in[31:16] = 16'h5555;
    goto_edge(6);
    check("tmo_armed", commit_pending, 1);
    goto_edge(56);
    check("tmo_clear56", commit_timeout, 0);
    goto_edge(105);
    check("tmo_clear105", commit_timeout, 0);
    goto_edge(106);
    check("tmo_set", commit_timeout, 1);
    check("tmo_still_armed", commit_pending, 1);
    idle_window = 1'b1;
    goto_edge(107);
    exp_out[31:16] = 16'h5555;
    check("tmo_commit", cfg_out, exp_out);
    idle_window = 1'b0;
    goto_edge(110);
    check("tmo_sticky", commit_timeout, 1);
`else
    goto_edge(10);
    check("tmo_tied0", commit_timeout, 0);
    check("post_rst_idle", commit_pending, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
